seed_rng: RTL and testbench



---
 rtl/seed_rng_pkg.sv | 23 ++
 rtl/seed_rng_lfsr.sv | 28 ++
 rtl/seed_rng.sv | 142 ++++++++++++++
 tb/tb_seed_rng.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seed_rng_pkg.sv
// rtl/seed_rng_pkg.sv - shared constants, state enum and LFSR step function for seed_rng
package seed_rng_pkg;

  localparam int WIDTH     = 12;
  localparam int MAX_TRIES = 16;

  // Right-shift Galois taps for x^12+x^11+x^10+x^4+1
  localparam logic [WIDTH-1:0] LFSR_TAPS     = 12'hE08;
  // Loaded instead of an all-zero seed, which would lock the LFSR
  localparam logic [WIDTH-1:0] LFSR_FALLBACK = 12'h001;

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    READY    = 2'd1,
    GEN      = 2'd2,
    REDUCE   = 2'd3
  } rng_state_t;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/seed_rng_lfsr.sv
// rtl/seed_rng_lfsr.sv - rng_lfsr: 12-bit Galois LFSR with load, step and zero-guard
module rng_lfsr
  import seed_rng_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_seed,
  input  logic             i_step,
  output logic [WIDTH-1:0] o_next
);

  logic [WIDTH-1:0] r_state;

  assign o_next = lfsr_next(r_state);

  // Load beats step; a zero seed is replaced so the state never reaches 0
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= LFSR_FALLBACK;
    end else if (i_load) begin
      r_state <= (i_seed == '0) ? LFSR_FALLBACK : i_seed;
    end else if (i_step) begin
      r_state <= o_next;
    end
  end

endmodule

// File: rtl/seed_rng.sv
// rtl/seed_rng.sv - seeded bounded RNG: FSM and reduction datapath (optional SEED_RNG_REJECT_EN)
module seed_rng
  import seed_rng_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_seed,
  input  logic             i_seed_load,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_bound,
  output logic [WIDTH-1:0] o_rnd,
  output logic             o_rnd_valid,
  output logic             o_busy,
  output logic             o_seeded
);

  // Bound of 0 stands for the full 4096-value range, hence the extra bit
  localparam logic [WIDTH:0] FULL_RANGE = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] ONE        = {{WIDTH{1'b0}}, 1'b1};

  rng_state_t       r_state, w_state_nxt;
  logic [WIDTH:0]   r_bound, r_v, w_v_nxt;
  logic [WIDTH:0]   w_cand, w_diff;
  logic [WIDTH-1:0] w_lfsr_next, w_emit_val;
  logic [WIDTH-1:0] r_rnd;
  logic             r_rnd_valid, r_seeded;
  logic             w_emit, w_accept, w_last_try;

  rng_lfsr u_lfsr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (i_seed_load),
    .i_seed  (i_seed),
    .i_step  (r_state == GEN),
    .o_next  (w_lfsr_next)
  );

  // Candidate is next LFSR state minus one, so the range is 0..4094
  assign w_cand = {1'b0, w_lfsr_next} - ONE;
  assign w_diff = r_v - r_bound;

`ifdef SEED_RNG_REJECT_EN
  localparam int TRY_W = $clog2(MAX_TRIES);
  logic [TRY_W-1:0] r_tries;

  // Counts GEN cycles of the current request to cap rejection retries
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tries <= '0;
    end else if (w_accept) begin
      r_tries <= '0;
    end else if (r_state == GEN) begin
      r_tries <= r_tries + TRY_W'(1);
    end
  end

  assign w_last_try = (r_tries == TRY_W'(MAX_TRIES - 1));
`else
  assign w_last_try = 1'b1;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= UNSEEDED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, emit decision and reduction value; seed_load overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_emit_val  = w_cand[WIDTH-1:0];
    w_v_nxt     = r_v;
    w_accept    = 1'b0;
    case (r_state)
      UNSEEDED: begin
      end
      READY: begin
        if (i_req) begin
          w_accept    = 1'b1;
          w_state_nxt = GEN;
        end
      end
      GEN: begin
        if (w_cand < r_bound) begin
          w_emit      = 1'b1;
          w_state_nxt = READY;
        end else if (w_last_try) begin
          w_v_nxt     = w_cand;
          w_state_nxt = REDUCE;
        end
      end
      REDUCE: begin
        w_emit_val = w_diff[WIDTH-1:0];
        if (w_diff < r_bound) begin
          w_emit      = 1'b1;
          w_state_nxt = READY;
        end else begin
          w_v_nxt = w_diff;
        end
      end
      default: w_state_nxt = UNSEEDED;
    endcase
    if (i_seed_load) begin
      w_state_nxt = READY;
      w_emit      = 1'b0;
      w_accept    = 1'b0;
    end
  end

  // Result, valid pulse, seeded flag and request operands
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rnd       <= '0;
      r_rnd_valid <= 1'b0;
      r_seeded    <= 1'b0;
      r_bound     <= '0;
      r_v         <= '0;
    end else begin
      r_rnd_valid <= w_emit;
      if (w_emit) begin
        r_rnd <= w_emit_val;
      end
      if (i_seed_load) begin
        r_seeded <= 1'b1;
      end
      if (w_accept) begin
        r_bound <= (i_bound == '0) ? FULL_RANGE : {1'b0, i_bound};
      end
      r_v <= w_v_nxt;
    end
  end

  assign o_rnd       = r_rnd;
  assign o_rnd_valid = r_rnd_valid;
  assign o_busy      = (r_state == GEN) || (r_state == REDUCE);
  assign o_seeded    = r_seeded;

endmodule

// File: tb/tb_seed_rng.sv
// tb/tb_seed_rng.sv - directed self-checking bench for seed_rng
module tb_seed_rng;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] seed;
  logic        seed_load;
  logic        req;
  logic [11:0] bound;
  logic [11:0] rnd;
  logic        rnd_valid;
  logic        busy;
  logic        seeded;

  int errors = 0;
  int checks = 0;
  logic [11:0] prior_rnd;

  seed_rng dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_seed      (seed),
    .i_seed_load (seed_load),
    .i_req       (req),
    .i_bound     (bound),
    .o_rnd       (rnd),
    .o_rnd_valid (rnd_valid),
    .o_busy      (busy),
    .o_seeded    (seeded)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seed(input logic [11:0] s);
    seed      = s;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  // Issues one request and measures latency (req edge = cycle N, result at N+lat) and busy cycles
  task automatic run_req(input logic [11:0] b, output int lat, output int busy_cnt, output bit got);
    req   = 1'b1;
    bound = b;
    tick();
    req      = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    got      = 1'b0;
    for (int i = 0; i < 6000 && !got; i++) begin
      if (rnd_valid) begin
        got = 1'b1;
      end else begin
        if (busy) busy_cnt++;
        tick();
        lat++;
      end
    end
  endtask

`ifdef SEED_RNG_REJECT_EN
  function automatic logic [11:0] m_next(input logic [11:0] s);
    return s[0] ? ((s >> 1) ^ 12'hE08) : (s >> 1);
  endfunction

  function automatic void model(input logic [11:0] s0, input logic [11:0] b,
                                output logic [11:0] r, output int lat);
    int bb;
    int v;
    logic [11:0] s;
    bb = (b == 12'd0) ? 4096 : int'(b);
    s  = s0;
    v  = 0;
    for (int t = 1; t <= 16; t++) begin
      s = m_next(s);
      v = int'(s) - 1;
      if (v < bb) begin
        r   = v[11:0];
        lat = t + 1;
        return;
      end
    end
    lat = 17 + (v / bb);
    v   = v % bb;
    r   = v[11:0];
  endfunction
`endif

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (rnd !== 12'h000) begin errors++; $display("FAIL reset_rnd got=%h exp=%h", rnd, 12'h000); end
    checks++; if (rnd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rnd_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (seeded !== 1'b0) begin errors++; $display("FAIL reset_seeded got=%b exp=0", seeded); end
  endtask

  task automatic test_unseeded_req();
    bit bad;
    req   = 1'b1;
    bound = 12'h005;
    tick();
    req = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (busy !== 1'b0 || rnd_valid !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++; if (bad) begin errors++; $display("FAIL unseeded_quiet got=busy/valid asserted exp=none"); end
    checks++; if (seeded !== 1'b0) begin errors++; $display("FAIL unseeded_seeded got=%b exp=0", seeded); end
    checks++; if (rnd !== 12'h000) begin errors++; $display("FAIL unseeded_rnd got=%h exp=000", rnd); end
  endtask

  task automatic test_seed_zero_full_range();
    int lat, bc;
    bit got;
    load_seed(12'h000);
    checks++; if (seeded !== 1'b1) begin errors++; $display("FAIL seed0_seeded got=%b exp=1", seeded); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL seed0_busy got=%b exp=0", busy); end
    run_req(12'h000, lat, bc, got);
    checks++; if (!got) begin errors++; $display("FAIL full1_timeout got=no valid exp=valid"); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL full1_latency got=%0d exp=2", lat); end
    checks++; if (rnd !== 12'hE07) begin errors++; $display("FAIL full1_rnd got=%h exp=E07", rnd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full1_busy_fall got=%b exp=0", busy); end
    checks++; if (bc !== 1) begin errors++; $display("FAIL full1_busy_len got=%0d exp=1", bc); end
    tick();
    checks++; if (rnd_valid !== 1'b0) begin errors++; $display("FAIL full1_pulse got=%b exp=0", rnd_valid); end
    checks++; if (rnd !== 12'hE07) begin errors++; $display("FAIL full1_hold got=%h exp=E07", rnd); end
    run_req(12'h000, lat, bc, got);
    checks++; if (rnd !== 12'h703 || !got) begin errors++; $display("FAIL full2_rnd got=%h exp=703", rnd); end
    tick();
  endtask

  task automatic test_reduce();
    int lat, bc, exp_lat;
    bit got;
    logic [11:0] exp_rnd;
`ifdef SEED_RNG_REJECT_EN
    model(12'h001, 12'h100, exp_rnd, exp_lat);
`else
    exp_rnd = 12'h007;
    exp_lat = 16;
`endif
    load_seed(12'h001);
    run_req(12'h100, lat, bc, got);
    checks++; if (!got) begin errors++; $display("FAIL reduce_timeout got=no valid exp=valid"); end
    checks++; if (rnd !== exp_rnd) begin errors++; $display("FAIL reduce_rnd got=%h exp=%h", rnd, exp_rnd); end
    checks++; if (lat !== exp_lat) begin errors++; $display("FAIL reduce_latency got=%0d exp=%0d", lat, exp_lat); end
    checks++; if (bc !== exp_lat - 1) begin errors++; $display("FAIL reduce_busy_len got=%0d exp=%0d", bc, exp_lat - 1); end
    prior_rnd = exp_rnd;
    tick();
  endtask

  task automatic test_abort();
    int lat, bc;
    bit got, bad;
    load_seed(12'h001);
    req   = 1'b1;
    bound = 12'h100;
    tick();
    req = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got=%b exp=1", busy); end
    load_seed(12'h0A5);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_ready got=%b exp=0", busy); end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rnd_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++; if (bad) begin errors++; $display("FAIL abort_no_valid got=valid/busy seen exp=none"); end
    checks++; if (rnd !== prior_rnd) begin errors++; $display("FAIL abort_rnd_hold got=%h exp=%h", rnd, prior_rnd); end
    run_req(12'h000, lat, bc, got);
    checks++; if (rnd !== 12'hE59 || lat !== 2) begin errors++; $display("FAIL abort_new_seed got=%h lat=%0d exp=E59 lat=2", rnd, lat); end
    tick();
  endtask

  task automatic test_load_req_same();
    int lat, bc;
    bit got, bad;
    seed      = 12'h123;
    seed_load = 1'b1;
    req       = 1'b1;
    bound     = 12'h000;
    tick();
    seed_load = 1'b0;
    req       = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (busy !== 1'b0 || rnd_valid !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++; if (bad) begin errors++; $display("FAIL same_req_dropped got=busy/valid seen exp=none"); end
    run_req(12'h000, lat, bc, got);
    checks++; if (rnd !== 12'hE98 || !got) begin errors++; $display("FAIL same_seed_loaded got=%h exp=E98", rnd); end
    tick();
  endtask

  task automatic test_bound_one();
    int lat, bc;
    bit got;
    load_seed(12'h001);
    run_req(12'h001, lat, bc, got);
    checks++; if (!got || rnd !== 12'h000) begin errors++; $display("FAIL bound1_rnd got=%h exp=000", rnd); end
`ifndef SEED_RNG_REJECT_EN
    checks++; if (lat !== 3593) begin errors++; $display("FAIL bound1_latency got=%0d exp=3593", lat); end
`endif
    tick();
  endtask

  initial begin
    reset     = 1'b1;
    seed      = 12'h000;
    seed_load = 1'b0;
    req       = 1'b0;
    bound     = 12'h000;
    prior_rnd = 12'h000;
    test_reset();
    test_unseeded_req();
    test_seed_zero_full_range();
    test_reduce();
    test_abort();
    test_load_req_same();
    test_bound_one();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
